// File: rtl/blast_pkg.sv
// Shared types and constants for the multi-channel blast controller.
package blast_pkg;

    localparam int unsigned COORD_W = 11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXPLODE = 2'd1,
        S_FADE    = 2'd2
    } blast_st_t;

    localparam logic signed [COORD_W-1:0] OFFSCREEN_X = 11'sd640;
    localparam logic signed [COORD_W-1:0] OFFSCREEN_Y = 11'sd480;

endpackage

// File: rtl/blast_multi_if.sv
// Bomb-controller request bus and per-channel blast outputs.
// Optional BLAST_FADE_EN adds the per-channel fading vector.
interface blast_multi_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned RAD_W = 2
);
    import blast_pkg::*;

    logic                       OneSecPulse;
    logic                       startOfFrame;
    logic                       blast;
    logic [RAD_W-1:0]           blastRadius;
    logic [COORD_W-1:0]         bomb_topLeftX;
    logic [COORD_W-1:0]         bomb_topLeftY;

    logic signed [COORD_W-1:0]  topLeftX [N_CH];
    logic signed [COORD_W-1:0]  topLeftY [N_CH];
    logic [RAD_W-1:0]           radius   [N_CH];
    logic [N_CH-1:0]            explode;
    logic                       anyExplode;
    logic                       full;
    logic                       dropped;
`ifdef BLAST_FADE_EN
    logic [N_CH-1:0]            fading;
`endif

    modport master (
        output OneSecPulse, startOfFrame, blast, blastRadius, bomb_topLeftX, bomb_topLeftY,
        input  topLeftX, topLeftY, radius, explode, anyExplode, full, dropped
`ifdef BLAST_FADE_EN
        , input fading
`endif
    );

    modport slave (
        input  OneSecPulse, startOfFrame, blast, blastRadius, bomb_topLeftX, bomb_topLeftY,
        output topLeftX, topLeftY, radius, explode, anyExplode, full, dropped
`ifdef BLAST_FADE_EN
        , output fading
`endif
    );

endinterface

// File: rtl/blast_slot.sv
// One blast channel: idle/explode(/fade) FSM, second and frame counters, registered outputs.
// With BLAST_FADE_EN the channel lingers in S_FADE for FADE_FRM frames after exploding.
module blast_slot
    import blast_pkg::*;
#(
    parameter int unsigned RAD_W      = 2,
    parameter int unsigned BLAST_SECS = 1
`ifdef BLAST_FADE_EN
    , parameter int unsigned FADE_FRM = 8
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      one_sec,
`ifdef BLAST_FADE_EN
    input  logic                      sof,
    output logic                      fading_c,
`endif
    input  logic                      arm,
    input  logic signed [COORD_W-1:0] arm_x,
    input  logic signed [COORD_W-1:0] arm_y,
    input  logic [RAD_W-1:0]          arm_r,
    output logic                      idle_c,
    output logic signed [COORD_W-1:0] top_left_x,
    output logic signed [COORD_W-1:0] top_left_y,
    output logic [RAD_W-1:0]          radius,
    output logic                      explode
);

    localparam int unsigned SEC_W = 4;

    blast_st_t                 state_q, state_d;
    logic [SEC_W-1:0]          sec_cnt_q, sec_cnt_d;
    logic signed [COORD_W-1:0] x_d, y_d;
    logic [RAD_W-1:0]          r_d;
    logic                      explode_d;

`ifdef BLAST_FADE_EN
    localparam int unsigned FADE_W = $clog2(FADE_FRM + 1);
    logic [FADE_W-1:0]         fade_cnt_q, fade_cnt_d;

    assign fading_c = (state_q == S_FADE);
`endif

    assign idle_c = (state_q == S_IDLE);

    // State, counters and outputs register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sec_cnt_q  <= '0;
            top_left_x <= OFFSCREEN_X;
            top_left_y <= OFFSCREEN_Y;
            radius     <= RAD_W'(1);
            explode    <= 1'b0;
`ifdef BLAST_FADE_EN
            fade_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sec_cnt_q  <= sec_cnt_d;
            top_left_x <= x_d;
            top_left_y <= y_d;
            radius     <= r_d;
            explode    <= explode_d;
`ifdef BLAST_FADE_EN
            fade_cnt_q <= fade_cnt_d;
`endif
        end
    end

    // Next state and next output values
    always_comb begin
        state_d   = state_q;
        sec_cnt_d = sec_cnt_q;
        x_d       = top_left_x;
        y_d       = top_left_y;
        r_d       = radius;
        explode_d = explode;
`ifdef BLAST_FADE_EN
        fade_cnt_d = fade_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d   = S_EXPLODE;
                    sec_cnt_d = '0;
                    x_d       = arm_x;
                    y_d       = arm_y;
                    r_d       = arm_r;
                    explode_d = 1'b1;
                end
            end
            S_EXPLODE: begin
                if (one_sec) begin
                    if (sec_cnt_q == SEC_W'(BLAST_SECS - 1)) begin
                        explode_d = 1'b0;
`ifdef BLAST_FADE_EN
                        state_d    = S_FADE;
                        fade_cnt_d = '0;
`else
                        state_d = S_IDLE;
                        x_d     = OFFSCREEN_X;
                        y_d     = OFFSCREEN_Y;
`endif
                    end else begin
                        sec_cnt_d = sec_cnt_q + SEC_W'(1);
                    end
                end
            end
            S_FADE: begin
`ifdef BLAST_FADE_EN
                if (sof) begin
                    if (fade_cnt_q == FADE_W'(FADE_FRM - 1)) begin
                        state_d = S_IDLE;
                        x_d     = OFFSCREEN_X;
                        y_d     = OFFSCREEN_Y;
                    end else begin
                        fade_cnt_d = fade_cnt_q + FADE_W'(1);
                    end
                end
`else
                state_d = S_IDLE;
                x_d     = OFFSCREEN_X;
                y_d     = OFFSCREEN_Y;
`endif
            end
            default: begin
                state_d   = S_IDLE;
                explode_d = 1'b0;
                x_d       = OFFSCREEN_X;
                y_d       = OFFSCREEN_Y;
            end
        endcase
    end

endmodule

// File: rtl/blast_multi.sv
// Multi-channel blast controller: edge-detects blast requests and hands each to the lowest idle channel.
// Define BLAST_FADE_EN to add a post-explosion fade phase and the fading output.
module blast_multi
    import blast_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned RAD_W      = 2,
    parameter int unsigned BLAST_SECS = 1,
    parameter int unsigned TILE       = 32,
    parameter int unsigned FADE_FRM   = 8
) (
    input  logic         clk,
    input  logic         reset,
    blast_multi_if.slave bus
);

    logic                      blast_q;
    logic                      req;
    logic                      dropped_q;
    logic [N_CH-1:0]           idle_c;
    logic [N_CH-1:0]           arm;
    logic [N_CH-1:0]           explode_v;
    logic [RAD_W-1:0]          rad_eff;
    logic [COORD_W-1:0]        offset;
    logic signed [COORD_W-1:0] arm_x, arm_y;
    logic signed [COORD_W-1:0] x_v [N_CH];
    logic signed [COORD_W-1:0] y_v [N_CH];
    logic [RAD_W-1:0]          r_v [N_CH];

`ifndef BLAST_FADE_EN
    localparam int unsigned unused_fade_frm = FADE_FRM;
    logic unused_sof;
    assign unused_sof = bus.startOfFrame;
`endif

    // Edge detect and drop pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            blast_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            blast_q   <= bus.blast;
            dropped_q <= req & ~(|idle_c);
        end
    end

    assign req = bus.blast & ~blast_q;

    // Isolate the lowest idle channel; frees this cycle are not yet visible in idle_c
    assign arm = req ? (idle_c & (~idle_c + N_CH'(1))) : '0;

    assign rad_eff = (bus.blastRadius == '0) ? RAD_W'(1) : bus.blastRadius;
    assign offset  = COORD_W'(rad_eff) * COORD_W'(TILE);
    assign arm_x   = $signed(bus.bomb_topLeftX - offset);
    assign arm_y   = $signed(bus.bomb_topLeftY - offset);

    for (genvar g = 0; g < N_CH; g++) begin : g_slot
        blast_slot #(
            .RAD_W      (RAD_W),
            .BLAST_SECS (BLAST_SECS)
`ifdef BLAST_FADE_EN
            , .FADE_FRM (FADE_FRM)
`endif
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .one_sec    (bus.OneSecPulse),
`ifdef BLAST_FADE_EN
            .sof        (bus.startOfFrame),
            .fading_c   (bus.fading[g]),
`endif
            .arm        (arm[g]),
            .arm_x      (arm_x),
            .arm_y      (arm_y),
            .arm_r      (rad_eff),
            .idle_c     (idle_c[g]),
            .top_left_x (x_v[g]),
            .top_left_y (y_v[g]),
            .radius     (r_v[g]),
            .explode    (explode_v[g])
        );

        assign bus.topLeftX[g] = x_v[g];
        assign bus.topLeftY[g] = y_v[g];
        assign bus.radius[g]   = r_v[g];
    end

    assign bus.explode    = explode_v;
    assign bus.anyExplode = |explode_v;
    assign bus.full       = ~(|idle_c);
    assign bus.dropped    = dropped_q;

endmodule

// File: tb/tb_blast_multi.sv
// Directed bench for blast_multi with an event-level channel model checked every cycle.
module tb_blast_multi;

    localparam int unsigned N_CH       = 4;
    localparam int unsigned RAD_W      = 2;
    localparam int unsigned BLAST_SECS = 2;
    localparam int unsigned TILE       = 32;
    localparam int unsigned FADE_FRM   = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    blast_multi_if #(.N_CH(N_CH), .RAD_W(RAD_W)) bus ();

    blast_multi #(
        .N_CH(N_CH), .RAD_W(RAD_W), .BLAST_SECS(BLAST_SECS), .TILE(TILE), .FADE_FRM(FADE_FRM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int wrap11(input int v);
        logic signed [10:0] t;
        t = 11'(v);
        return int'(t);
    endfunction

    // Channel model: 0 = free, 1 = exploding, 2 = fading
    int m_mode   [N_CH];
    int m_x      [N_CH];
    int m_y      [N_CH];
    int m_r      [N_CH];
    int m_secs   [N_CH];
    int m_frames [N_CH];
    bit m_prev;
    bit m_drop;

    always @(posedge clk) begin
        int tgt;
        int rr;
        bit rq;
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                m_mode[i] = 0; m_x[i] = 640; m_y[i] = 480; m_r[i] = 1;
                m_secs[i] = 0; m_frames[i] = 0;
            end
            m_prev = 1'b0;
            m_drop = 1'b0;
        end else begin
            rq = bus.blast && !m_prev;
            m_prev = bus.blast;
            tgt = -1;
            for (int i = N_CH - 1; i >= 0; i--)
                if (m_mode[i] == 0) tgt = i;
            for (int i = 0; i < N_CH; i++) begin
                if (m_mode[i] == 1 && bus.OneSecPulse) begin
                    m_secs[i]++;
                    if (m_secs[i] >= BLAST_SECS) begin
`ifdef BLAST_FADE_EN
                        m_mode[i] = 2; m_frames[i] = 0;
`else
                        m_mode[i] = 0; m_x[i] = 640; m_y[i] = 480;
`endif
                    end
                end else if (m_mode[i] == 2 && bus.startOfFrame) begin
                    m_frames[i]++;
                    if (m_frames[i] >= FADE_FRM) begin
                        m_mode[i] = 0; m_x[i] = 640; m_y[i] = 480;
                    end
                end
            end
            m_drop = rq && (tgt < 0);
            if (rq && tgt >= 0) begin
                rr = (bus.blastRadius == 0) ? 1 : int'(bus.blastRadius);
                m_mode[tgt] = 1;
                m_secs[tgt] = 0;
                m_r[tgt]    = rr;
                m_x[tgt]    = wrap11(int'(bus.bomb_topLeftX) - rr * int'(TILE));
                m_y[tgt]    = wrap11(int'(bus.bomb_topLeftY) - rr * int'(TILE));
            end
        end
        #1;
        if (chk_en) begin
            bit any_e;
            bit all_b;
            any_e = 1'b0;
            all_b = 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                chk($sformatf("model explode[%0d]", i), int'(bus.explode[i]), int'(m_mode[i] == 1));
                chk($sformatf("model topLeftX[%0d]", i), int'(bus.topLeftX[i]), m_x[i]);
                chk($sformatf("model topLeftY[%0d]", i), int'(bus.topLeftY[i]), m_y[i]);
                chk($sformatf("model radius[%0d]", i), int'(bus.radius[i]), m_r[i]);
`ifdef BLAST_FADE_EN
                chk($sformatf("model fading[%0d]", i), int'(bus.fading[i]), int'(m_mode[i] == 2));
`endif
                if (m_mode[i] == 1) any_e = 1'b1;
                if (m_mode[i] == 0) all_b = 1'b0;
            end
            chk("model anyExplode", int'(bus.anyExplode), int'(any_e));
            chk("model full", int'(bus.full), int'(all_b));
            chk("model dropped", int'(bus.dropped), int'(m_drop));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One request: one low cycle, then blast high for one edge; leaves blast low afterwards
    task automatic fire(input int r, input int x, input int y, input bit sec);
        step();
        bus.blast         = 1'b1;
        bus.blastRadius   = RAD_W'(r);
        bus.bomb_topLeftX = 11'(x);
        bus.bomb_topLeftY = 11'(y);
        bus.OneSecPulse   = sec;
        step();
        bus.blast       = 1'b0;
        bus.OneSecPulse = 1'b0;
    endtask

    task automatic sec_pulse();
        bus.OneSecPulse = 1'b1;
        step();
        bus.OneSecPulse = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        bus.OneSecPulse   = 1'b0;
        bus.startOfFrame  = 1'b0;
        bus.blast         = 1'b0;
        bus.blastRadius   = '0;
        bus.bomb_topLeftX = '0;
        bus.bomb_topLeftY = '0;
        repeat (3) step();
        chk_en = 1'b1;

        chk("reset topLeftX0", int'(bus.topLeftX[0]), 640);
        chk("reset topLeftY3", int'(bus.topLeftY[3]), 480);
        chk("reset radius1", int'(bus.radius[1]), 1);
        chk("reset explode", int'(bus.explode), 0);
        chk("reset full", int'(bus.full), 0);
        reset = 1'b0;
        step();

        // Arm ch0 with a OneSecPulse in the arm cycle (must be ignored)
        fire(2, 320, 240, 1'b1);
        chk("arm explode0", int'(bus.explode[0]), 1);
        chk("arm topLeftX0", int'(bus.topLeftX[0]), 256);
        chk("arm topLeftY0", int'(bus.topLeftY[0]), 176);
        chk("arm radius0", int'(bus.radius[0]), 2);
        step();
        sec_pulse();
        chk("1st sec explode0", int'(bus.explode[0]), 1);
        step();
        sec_pulse();
`ifndef BLAST_FADE_EN
        chk("2nd sec explode0", int'(bus.explode[0]), 0);
        chk("2nd sec topLeftX0", int'(bus.topLeftX[0]), 640);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Fill all channels, ch0 one second ahead, then overflow
        fire(1, 100, 100, 1'b0);
        sec_pulse();
        fire(2, 200, 50, 1'b0);
        fire(3, 600, 400, 1'b0);
        fire(0, 5, 5, 1'b0);
        chk("fill full", int'(bus.full), 1);
        chk("fill explode", int'(bus.explode), 15);
        chk("fill topLeftX2", int'(bus.topLeftX[2]), 504);
        chk("fill topLeftY3", int'(bus.topLeftY[3]), -27);
        fire(1, 50, 50, 1'b0);
        chk("overflow dropped", int'(bus.dropped), 1);
        chk("overflow explode", int'(bus.explode), 15);
        step();
        chk("dropped one cycle", int'(bus.dropped), 0);

        // Request in the same cycle ch0 expires
        fire(2, 64, 64, 1'b1);
        chk("expire+req dropped", int'(bus.dropped), 1);
`ifndef BLAST_FADE_EN
        chk("expire+req explode", int'(bus.explode), 14);
`endif
        fire(2, 64, 64, 1'b0);
`ifndef BLAST_FADE_EN
        chk("rearm ch0 explode", int'(bus.explode), 15);
        chk("rearm ch0 topLeftX", int'(bus.topLeftX[0]), 0);
`endif
        step();
        sec_pulse();
`ifndef BLAST_FADE_EN
        chk("multi expire", int'(bus.explode), 1);
`endif
        sec_pulse();

        // Reset mid-operation
        fire(3, 400, 300, 1'b0);
        reset = 1'b1;
        step();
        chk("midreset explode", int'(bus.explode), 0);
        chk("midreset topLeftX0", int'(bus.topLeftX[0]), 640);
        reset = 1'b0;
        step();

        // Radius 0 with a long held blast
        bus.blast         = 1'b1;
        bus.blastRadius   = '0;
        bus.bomb_topLeftX = 11'd10;
        bus.bomb_topLeftY = 11'd10;
        step();
        chk("r0 topLeftX0", int'(bus.topLeftX[0]), -22);
        chk("r0 radius0", int'(bus.radius[0]), 1);
        repeat (19) step();
        bus.blast = 1'b0;
        step();
        chk("held blast one channel", int'(bus.explode), 1);
        sec_pulse();
        step();
        sec_pulse();
        chk("r0 expired", int'(bus.explode), 0);

`ifdef BLAST_FADE_EN
        // Fade lasts exactly FADE_FRM frames, then a mid-fade reset
        for (int k = 0; k < int'(FADE_FRM); k++) begin
            chk("fading during fade", int'(bus.fading[0]), 1);
            bus.startOfFrame = 1'b1;
            step();
            bus.startOfFrame = 1'b0;
            step();
        end
        chk("fade done", int'(bus.fading[0]), 0);
        chk("fade done topLeftX0", int'(bus.topLeftX[0]), 640);
        fire(1, 300, 300, 1'b0);
        sec_pulse();
        sec_pulse();
        chk("fade entered", int'(bus.fading[0]), 1);
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
        reset = 1'b1;
        step();
        chk("midfade reset", int'(bus.fading), 0);
        reset = 1'b0;
`endif

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
